// File: rtl/moneyin_edge_debouncer.sv
// -----------------------------------------------------------------------------
// moneyin_edge_debouncer
//   Per-channel synchroniser + stability-counter debouncer + qualified edge
//   pulse generator. Sits between the coin/button pins and the vending FSM.
//
//   Parameters:
//     N           number of channels (>=1)
//     SYNC_STAGES synchroniser depth per channel (>=2)
//     DEB_CYCLES  consecutive synchronised cycles of a new level before it is
//                 accepted (>=1)
//     MODE        edge qualifier: 0 rising, 1 falling, 2 both
//
//   Ports:
//     clk        system clock, all state on the rising edge
//     reset_n    asynchronous active-low reset
//     din[N]     raw asynchronous level inputs
//     en         pulse enable (debouncing keeps running while low)
//     pulse[N]   registered one-cycle pulse on a qualified accepted edge
//     level[N]   registered debounced level
//     any_pulse  OR of the pulse register
//     event_cnt  (only with MONEYIN_EVENT_CNT_EN) saturating 8-bit count of
//                visible pulses, cleared only by reset_n
//
//   Optional feature macro: MONEYIN_EVENT_CNT_EN
// -----------------------------------------------------------------------------

// One channel: sync chain, stability counter, level and pulse registers.
module moneyin_deb_lane #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEB_CYCLES  = 4,
   parameter int unsigned MODE        = 0,
   parameter int unsigned CW          = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   input  logic en,
   output logic pulse,
   output logic level
);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt;
   logic                   s;
   logic                   qual;

   assign s = sync_q[SYNC_STAGES-1];

   // Qualifier is evaluated against the level about to be accepted (s).
   always_comb begin
      qual = 1'b1;
      case (MODE)
         0:       qual = s;
         1:       qual = ~s;
         default: qual = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         cnt    <= '0;
         level  <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         pulse  <= 1'b0;
         if (s == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            // Acceptance: new level and its pulse appear on the same edge.
            level <= s;
            cnt   <= '0;
            pulse <= en & qual;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

module moneyin_edge_debouncer #(
   parameter int unsigned N           = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEB_CYCLES  = 4,
   parameter int unsigned MODE        = 0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] din,
   input  logic         en,
   output logic [N-1:0] pulse,
   output logic [N-1:0] level,
   output logic         any_pulse
`ifdef MONEYIN_EVENT_CNT_EN
   ,
   output logic [7:0]   event_cnt
`endif
);
   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

   generate
      if (N < 1 || MODE > 2 || SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_bad_param
         $error("moneyin_edge_debouncer: illegal parameter value");
      end
   endgenerate

   generate
      for (genvar i = 0; i < N; i++) begin : g_lane
         moneyin_deb_lane #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_CYCLES (DEB_CYCLES),
            .MODE       (MODE),
            .CW         (CW)
         ) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (din[i]),
            .en     (en),
            .pulse  (pulse[i]),
            .level  (level[i])
         );
      end
   endgenerate

   assign any_pulse = |pulse;

`ifdef MONEYIN_EVENT_CNT_EN
   // Adds the pulses currently visible in the pulse register, saturating.
   logic [15:0] pc;
   logic [15:0] sum;

   always_comb begin
      pc = '0;
      for (int i = 0; i < N; i++) pc = pc + 16'(pulse[i]);
      sum = {8'b0, event_cnt} + pc;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          event_cnt <= '0;
      else if (sum > 16'd255) event_cnt <= 8'hFF;
      else                   event_cnt <= sum[7:0];
   end
`endif
endmodule

// File: tb/tb_moneyin_edge_debouncer.sv
// -----------------------------------------------------------------------------
// tb_moneyin_edge_debouncer
//   Two instances share stimulus: dut0 with defaults (MODE 0, SYNC 2, DEB 4)
//   and dut1 with MODE 2, SYNC 3, DEB 3 (same total latency of 6 edges).
//   Table-driven vectors, hand-written corner sequences and a randomized
//   phase, all compared against a reference model that tracks, per channel,
//   the synchronised samples seen since the last acceptance.
// -----------------------------------------------------------------------------
module tb_moneyin_edge_debouncer;
   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       en = 1'b1;
   logic [3:0] din = 4'b0;
   logic [3:0] pulse0, level0, pulse1, level1;
   logic       any0, any1;
`ifdef MONEYIN_EVENT_CNT_EN
   logic [7:0] ec0, ec1;
`endif

   always #5 clk = ~clk;

   moneyin_edge_debouncer #(.N(4), .SYNC_STAGES(2), .DEB_CYCLES(4), .MODE(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .din(din), .en(en),
      .pulse(pulse0), .level(level0), .any_pulse(any0)
`ifdef MONEYIN_EVENT_CNT_EN
      , .event_cnt(ec0)
`endif
   );

   moneyin_edge_debouncer #(.N(4), .SYNC_STAGES(3), .DEB_CYCLES(3), .MODE(2)) dut1 (
      .clk(clk), .reset_n(reset_n), .din(din), .en(en),
      .pulse(pulse1), .level(level1), .any_pulse(any1)
`ifdef MONEYIN_EVENT_CNT_EN
      , .event_cnt(ec1)
`endif
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [3:0]  m_lvl[2];
   logic [3:0]  m_pulse[2];
   logic [3:0]  dhist[2][8];   // dhist[i][k] = din sampled k+1 edges ago
   logic [31:0] shist[2][4];   // synchronised samples, bit 0 newest
   int          nsince[2][4];  // samples seen since last acceptance/reset
   int          m_ec[2];

   function automatic int p_sync(int i); return (i == 0) ? 2 : 3; endfunction
   function automatic int p_deb(int i);  return (i == 0) ? 4 : 3; endfunction
   function automatic int p_mode(int i); return (i == 0) ? 0 : 2; endfunction

   function automatic logic qual(int m, logic v);
      if (m == 0) return v;
      if (m == 1) return ~v;
      return 1'b1;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_lvl[i] = '0; m_pulse[i] = '0; m_ec[i] = 0;
         for (int k = 0; k < 8; k++) dhist[i][k] = '0;
         for (int c = 0; c < 4; c++) begin shist[i][c] = '0; nsince[i][c] = 0; end
      end
   endfunction

   function automatic void model_edge();
      for (int i = 0; i < 2; i++) begin
         logic [3:0] s;
         logic [3:0] old;
         logic       acc;
         s   = dhist[i][p_sync(i)-1];
         old = m_pulse[i];
         for (int c = 0; c < 4; c++) begin
            shist[i][c] = {shist[i][c][30:0], s[c]};
            nsince[i][c]++;
            // accept once the last DEB samples since acceptance all differ
            acc = (nsince[i][c] >= p_deb(i));
            for (int j = 0; j < p_deb(i); j++)
               if (shist[i][c][j] == m_lvl[i][c]) acc = 1'b0;
            m_pulse[i][c] = 1'b0;
            if (acc) begin
               m_lvl[i][c]   = s[c];
               nsince[i][c]  = 0;
               m_pulse[i][c] = en & qual(p_mode(i), s[c]);
            end
         end
         m_ec[i] = m_ec[i] + $countones(old);
         if (m_ec[i] > 255) m_ec[i] = 255;
         for (int k = 7; k > 0; k--) dhist[i][k] = dhist[i][k-1];
         dhist[i][0] = din;
      end
   endfunction

   task automatic compare_all();
      chk("pulse0", 32'(pulse0), 32'(m_pulse[0]));
      chk("level0", 32'(level0), 32'(m_lvl[0]));
      chk("any0",   32'(any0),   32'(|m_pulse[0]));
      chk("pulse1", 32'(pulse1), 32'(m_pulse[1]));
      chk("level1", 32'(level1), 32'(m_lvl[1]));
      chk("any1",   32'(any1),   32'(|m_pulse[1]));
`ifdef MONEYIN_EVENT_CNT_EN
      chk("ec0", 32'(ec0), 32'(m_ec[0]));
      chk("ec1", 32'(ec1), 32'(m_ec[1]));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // ---------------- vectors ----------------
   typedef struct packed {
      logic [3:0] din;
      logic       en;
      logic [3:0] p0;   // dut0 pulse at edge 6
      logic [3:0] p2;   // dut1 pulse at edge 6
      logic [3:0] lvl;  // settled level
   } vec_t;

   vec_t tab[8];

   initial begin
      tab[0] = '{4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0001};
      tab[1] = '{4'b0011, 1'b1, 4'b0010, 4'b0010, 4'b0011};
      tab[2] = '{4'b0010, 1'b1, 4'b0000, 4'b0001, 4'b0010};
      tab[3] = '{4'b1010, 1'b0, 4'b0000, 4'b0000, 4'b1010};
      tab[4] = '{4'b0101, 1'b1, 4'b0101, 4'b1111, 4'b0101};
      tab[5] = '{4'b1111, 1'b1, 4'b1010, 4'b1010, 4'b1111};
      tab[6] = '{4'b0000, 1'b1, 4'b0000, 4'b1111, 4'b0000};
      tab[7] = '{4'b1111, 1'b1, 4'b1111, 4'b1111, 4'b1111};

      // reset state
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_pulse0", 32'(pulse0), 32'h0);
      chk("rst_level0", 32'(level0), 32'h0);
      chk("rst_any0",   32'(any0),   32'h0);
      compare_all();
      @(negedge clk);
      reset_n = 1'b1;

      // table: each row applies din/en before edge 1 and expects edge-6 pulses
      for (int r = 0; r < 8; r++) begin
         din = tab[r].din;
         en  = tab[r].en;
         for (int e = 1; e <= 8; e++) begin
            tick();
            chk($sformatf("tab%0d_p0_e%0d", r, e), 32'(pulse0), 32'((e == 6) ? tab[r].p0 : 4'b0));
            chk($sformatf("tab%0d_p2_e%0d", r, e), 32'(pulse1), 32'((e == 6) ? tab[r].p2 : 4'b0));
         end
         chk($sformatf("tab%0d_lvl0", r), 32'(level0), 32'(tab[r].lvl));
         chk($sformatf("tab%0d_lvl1", r), 32'(level1), 32'(tab[r].lvl));
      end

      // glitch: din[1] high for 3 sampled cycles is rejected by dut0
      en = 1'b1;
      din = 4'b0000;
      for (int e = 0; e < 8; e++) tick();
      din = 4'b0010;
      for (int e = 0; e < 3; e++) tick();
      din = 4'b0000;
      for (int e = 0; e < 12; e++) begin
         tick();
         chk("glitch_p0", 32'(pulse0), 32'h0);
         chk("glitch_l0", 32'(level0), 32'h0);
      end

      // en low during a rise, raised 10 edges later: no pulse ever
      din = 4'b1000;
      en  = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         if (e == 11) en = 1'b1;
         tick();
         chk("en_p0", 32'(pulse0), 32'h0);
         chk("en_l3", 32'(level0[3]), 32'((e >= 6) ? 1 : 0));
      end

      // reset mid-count discards the partial edge; pulse again 6 edges after release
      din = 4'b0101;
      for (int e = 0; e < 8; e++) tick();
      din = 4'b1111;
      for (int e = 0; e < 4; e++) tick();
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_level0", 32'(level0), 32'h0);
      chk("midrst_pulse0", 32'(pulse0), 32'h0);
      chk("midrst_any0",   32'(any0),   32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         chk($sformatf("rel_p0_e%0d", e), 32'(pulse0), 32'((e == 6) ? 4'b1111 : 4'b0));
         chk($sformatf("rel_any0_e%0d", e), 32'(any0), 32'((e == 6) ? 1 : 0));
      end

`ifdef MONEYIN_EVENT_CNT_EN
      // 85 four-channel rise/fall cycles saturate the counter at 255
      for (int c = 0; c < 85; c++) begin
         din = 4'b1111;
         for (int e = 0; e < 7; e++) tick();
         din = 4'b0000;
         for (int e = 0; e < 7; e++) tick();
      end
      chk("ec0_sat", 32'(ec0), 32'd255);
      chk("ec1_sat", 32'(ec1), 32'd255);
`endif

      // randomized: slowly varying din, random en, occasional reset
      for (int t = 0; t < 1500; t++) begin
         if ($urandom_range(0, 5) == 0) din[$urandom_range(0, 3)] = ~din[$urandom_range(0, 3)];
         if ($urandom_range(0, 9) == 0) en = ~en;
         if ($urandom_range(0, 299) == 0) do_reset();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
